// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART receive-path defaults and the FIFO operation encoding.
// Used by uart_fifo_ctrl and uart_rx_fifo.
package uart_rx_fifo_pkg;

   localparam int UART_DBIT        = 8;
   localparam int RX_FIFO_ADDR_W   = 4;
   localparam int RX_FIFO_WM_LEVEL = 12;

   // Encoded as {push accepted, pop accepted}
   typedef enum logic [1:0] {
      OP_NONE     = 2'b00,
      OP_POP      = 2'b01,
      OP_PUSH     = 2'b10,
      OP_PUSH_POP = 2'b11
   } fifo_op_t;

endpackage

// File: rtl/uart_fifo_ctrl.sv
// Pointer, occupancy and flag control for the UART receive FIFO.
// Optional watermark output is built only when RX_FIFO_WM_EN is defined.
module uart_fifo_ctrl
   import uart_rx_fifo_pkg::*;
#(
   parameter int ADDR_W   = RX_FIFO_ADDR_W,
   parameter int WM_LEVEL = RX_FIFO_WM_LEVEL
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              rd,
   input  logic              clr_overrun,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overrun,
   output logic              wm_hit
);

   localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_ONE = 1;
   localparam logic [ADDR_W-1:0] PTR_ONE = 1;

   if (WM_LEVEL < 1 || WM_LEVEL > (1 << ADDR_W)) begin : g_wm_range
      $error("uart_fifo_ctrl: WM_LEVEL outside 1..2**ADDR_W");
   end

   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   count_q, count_next;
   logic              push_ok, pop_ok, drop;
   fifo_op_t          op;

   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH);

   // A full FIFO still accepts a push when a pop frees the slot on the same edge
   always_comb begin
      pop_ok     = rd && !empty;
      push_ok    = push && (!full || pop_ok);
      drop       = push && full && !pop_ok;
      op         = fifo_op_t'({push_ok, pop_ok});
      count_next = count_q;
      case (op)
         OP_PUSH: count_next = count_q + CNT_ONE;
         OP_POP:  count_next = count_q - CNT_ONE;
         default: count_next = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         overrun <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
         count_q <= count_next;
         if (drop)             overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

`ifdef RX_FIFO_WM_EN
   localparam logic [ADDR_W:0] WM_THR = (ADDR_W+1)'(WM_LEVEL);

   logic wm_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) wm_q <= 1'b0;
      else       wm_q <= (count_next >= WM_THR);
   end

   assign wm_hit = wm_q;
`else
   assign wm_hit = 1'b0;
`endif

   assign wr_en   = push_ok;
   assign wr_addr = wr_ptr;
   assign rd_addr = rd_ptr;
   assign count   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: circular FIFO with first-word-fall-through read and sticky overrun.
// Define RX_FIFO_WM_EN to enable the registered wm_hit watermark flag.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DBIT     = UART_DBIT,
   parameter int ADDR_W   = RX_FIFO_ADDR_W,
   parameter int WM_LEVEL = RX_FIFO_WM_LEVEL
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_done_tick,
   input  logic [DBIT-1:0] rx_dout,
   input  logic            rd,
   output logic [DBIT-1:0] r_data,
   output logic            empty,
   output logic            full,
   output logic [ADDR_W:0] count,
   output logic            overrun,
   input  logic            clr_overrun,
   output logic            wm_hit
);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [DBIT-1:0]   mem [2**ADDR_W];

   uart_fifo_ctrl #(
      .ADDR_W   (ADDR_W),
      .WM_LEVEL (WM_LEVEL)
   ) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .push        (rx_done_tick),
      .rd          (rd),
      .clr_overrun (clr_overrun),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .rd_addr     (rd_addr),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .overrun     (overrun),
      .wm_hit      (wm_hit)
   );

   // Storage is deliberately not reset; empty masks stale contents
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= rx_dout;
   end

   assign r_data = empty ? '0 : mem[rd_addr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default ADDR_W=4, DBIT=8, WM_LEVEL=12).
// Build with RX_FIFO_WM_EN defined to exercise the watermark path.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_done_tick = 1'b0;
   logic [7:0] rx_dout = 8'h00;
   logic       rd = 1'b0;
   logic [7:0] r_data;
   logic       empty, full, overrun, wm_hit;
   logic [4:0] count;
   logic       clr_overrun = 1'b0;

   int checks = 0;
   int failures = 0;

   uart_rx_fifo #(.DBIT(8), .ADDR_W(4), .WM_LEVEL(12)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .rx_dout      (rx_dout),
      .rd           (rd),
      .r_data       (r_data),
      .empty        (empty),
      .full         (full),
      .count        (count),
      .overrun      (overrun),
      .clr_overrun  (clr_overrun),
      .wm_hit       (wm_hit)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rx_done_tick = 1'b0;
      rd = 1'b0;
      clr_overrun = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_dout = b;
      rx_done_tick = 1'b1;
      tick();
      rx_done_tick = 1'b0;
   endtask

   task automatic pop_byte;
      rd = 1'b1;
      tick();
      rd = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({empty, full, count, overrun, wm_hit, r_data} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL reset_state: got empty=%b full=%b count=%0d overrun=%b wm_hit=%b r_data=%h, want 1 0 0 0 0 00",
                  empty, full, count, overrun, wm_hit, r_data);
      end
   endtask

   task automatic test_single;
      do_reset();
      push_byte(8'hA5);
      checks++;
      if ({empty, r_data, count} !== {1'b0, 8'hA5, 5'd1}) begin
         failures++;
         $display("FAIL single_push: got empty=%b r_data=%h count=%0d, want 0 a5 1", empty, r_data, count);
      end
      pop_byte();
      checks++;
      if ({empty, r_data, count} !== {1'b1, 8'h00, 5'd0}) begin
         failures++;
         $display("FAIL single_pop: got empty=%b r_data=%h count=%0d, want 1 00 0", empty, r_data, count);
      end
      pop_byte();
      checks++;
      if ({empty, count, overrun, r_data} !== {1'b1, 5'd0, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL pop_empty: got empty=%b count=%0d overrun=%b r_data=%h, want 1 0 0 00",
                  empty, count, overrun, r_data);
      end
   endtask

   task automatic test_overrun;
      do_reset();
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      checks++;
      if ({full, count, overrun} !== {1'b1, 5'd16, 1'b0}) begin
         failures++;
         $display("FAIL fill16: got full=%b count=%0d overrun=%b, want 1 16 0", full, count, overrun);
      end
      push_byte(8'h55);
      checks++;
      if ({full, count, overrun} !== {1'b1, 5'd16, 1'b1}) begin
         failures++;
         $display("FAIL push_full: got full=%b count=%0d overrun=%b, want 1 16 1", full, count, overrun);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (r_data !== 8'(i)) begin
            failures++;
            $display("FAIL drain_order[%0d]: got %h, want %h", i, r_data, 8'(i));
         end
         pop_byte();
      end
      checks++;
      if ({empty, r_data, overrun} !== {1'b1, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL drained: got empty=%b r_data=%h overrun=%b, want 1 00 1", empty, r_data, overrun);
      end
   endtask

   task automatic test_full_push_pop;
      do_reset();
      for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
      rx_dout = 8'h77;
      rx_done_tick = 1'b1;
      rd = 1'b1;
      tick();
      rx_done_tick = 1'b0;
      rd = 1'b0;
      checks++;
      if ({full, count, overrun, r_data} !== {1'b1, 5'd16, 1'b0, 8'h11}) begin
         failures++;
         $display("FAIL full_push_pop: got full=%b count=%0d overrun=%b r_data=%h, want 1 16 0 11",
                  full, count, overrun, r_data);
      end
      for (int i = 1; i < 16; i++) pop_byte();
      checks++;
      if ({r_data, count} !== {8'h77, 5'd1}) begin
         failures++;
         $display("FAIL last_byte: got r_data=%h count=%0d, want 77 1", r_data, count);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] q[$];
      logic [7:0] exp_head;
      int pushed;
      int errs;
      do_reset();
      pushed = 0;
      errs = 0;
      for (int c = 0; c < 60; c++) begin
         rx_done_tick = (pushed < 40);
         rx_dout = 8'((pushed * 37) + 5);
         rd = (c >= 3) && (q.size() != 0) && (c % 5 != 0);
         exp_head = (q.size() != 0) ? q[0] : 8'h00;
         checks++;
         if (r_data !== exp_head) begin
            failures++;
            errs++;
            $display("FAIL b2b_data c=%0d: got %h, want %h", c, r_data, exp_head);
         end
         if (rd) void'(q.pop_front());
         if (rx_done_tick) begin
            q.push_back(rx_dout);
            pushed++;
         end
         tick();
         checks++;
         if ({empty, full, count} !== {q.size() == 0, q.size() == 16, 5'(q.size())}) begin
            failures++;
            errs++;
            $display("FAIL b2b_flags c=%0d: got empty=%b full=%b count=%0d, want %b %b %0d",
                     c, empty, full, count, q.size() == 0, q.size() == 16, q.size());
         end
         if (errs > 8) break;
      end
      rx_done_tick = 1'b0;
      rd = 1'b0;
      checks++;
      if ({empty, overrun, pushed} !== {1'b1, 1'b0, 32'd40}) begin
         failures++;
         $display("FAIL b2b_end: got empty=%b overrun=%b pushed=%0d, want 1 0 40", empty, overrun, pushed);
      end
   endtask

   task automatic test_overrun_clear;
      do_reset();
      for (int i = 0; i < 16; i++) push_byte(8'hC0 + 8'(i));
      push_byte(8'h55);
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL ovr_set: got %b, want 1", overrun);
      end
      clr_overrun = 1'b1;
      push_byte(8'h66);
      clr_overrun = 1'b0;
      checks++;
      if ({overrun, count} !== {1'b1, 5'd16}) begin
         failures++;
         $display("FAIL ovr_set_wins: got overrun=%b count=%0d, want 1 16", overrun, count);
      end
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      checks++;
      if ({overrun, count, r_data} !== {1'b0, 5'd16, 8'hC0}) begin
         failures++;
         $display("FAIL ovr_clear: got overrun=%b count=%0d r_data=%h, want 0 16 c0", overrun, count, r_data);
      end
   endtask

   task automatic test_watermark;
      do_reset();
`ifdef RX_FIFO_WM_EN
      for (int i = 0; i < 11; i++) push_byte(8'(i));
      checks++;
      if ({wm_hit, count} !== {1'b0, 5'd11}) begin
         failures++;
         $display("FAIL wm_11: got wm_hit=%b count=%0d, want 0 11", wm_hit, count);
      end
      push_byte(8'h0B);
      checks++;
      if ({wm_hit, count} !== {1'b1, 5'd12}) begin
         failures++;
         $display("FAIL wm_12: got wm_hit=%b count=%0d, want 1 12", wm_hit, count);
      end
      pop_byte();
      checks++;
      if ({wm_hit, count} !== {1'b0, 5'd11}) begin
         failures++;
         $display("FAIL wm_pop: got wm_hit=%b count=%0d, want 0 11", wm_hit, count);
      end
`else
      for (int i = 0; i < 16; i++) begin
         push_byte(8'(i));
         checks++;
         if ({wm_hit, count} !== {1'b0, 5'(i + 1)}) begin
            failures++;
            $display("FAIL wm_off[%0d]: got wm_hit=%b count=%0d, want 0 %0d", i, wm_hit, count, i + 1);
         end
      end
`endif
   endtask

   task automatic test_reset_mid_fill;
      do_reset();
      for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i));
      push_byte(8'hEE);
      checks++;
      if ({full, overrun, r_data} !== {1'b1, 1'b1, 8'h30}) begin
         failures++;
         $display("FAIL pre_reset: got full=%b overrun=%b r_data=%h, want 1 1 30", full, overrun, r_data);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({empty, full, count, overrun, wm_hit, r_data} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL async_reset: got empty=%b full=%b count=%0d overrun=%b wm_hit=%b r_data=%h, want 1 0 0 0 0 00",
                  empty, full, count, overrun, wm_hit, r_data);
      end
      tick();
      reset = 1'b0;
      push_byte(8'h3C);
      checks++;
      if ({r_data, count} !== {8'h3C, 5'd1}) begin
         failures++;
         $display("FAIL post_reset_push: got r_data=%h count=%0d, want 3c 1", r_data, count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overrun();
      test_full_push_pop();
      test_back_to_back();
      test_overrun_clear();
      test_watermark();
      test_reset_mid_fill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
